wb_stage: RTL and testbench

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_stage_pkg.sv | 29 ++
 rtl/wb_stage_if.sv | 20 ++
 rtl/wb_stage_load_align.sv | 33 +++
 rtl/wb_stage.sv | 75 +++++++
 tb/tb_wb_stage.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_stage_pkg.sv
// Shared constants for the write-back stage: load-type encodings and the
// layout of the MEM->WB bus.
package wb_stage_pkg;

  typedef enum logic [2:0] {
    LD_NONE = 3'd0,
    LD_B    = 3'd1,
    LD_BU   = 3'd2,
    LD_H    = 3'd3,
    LD_HU   = 3'd4,
    LD_W    = 3'd5
  } ld_op_e;

  typedef struct packed {
    logic [31:0] pc;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] result;
    logic [2:0]  ld_op;
  } ms_to_ws_bus_t;

  localparam int MS_TO_WS_BUS_WD = 73;

  // Encodings 6/7 are reserved and treated as "not a load".
  function automatic logic is_load(input logic [2:0] op);
    return (op >= 3'(LD_B)) && (op <= 3'(LD_W));
  endfunction

endpackage

// File: rtl/wb_stage_if.sv
// MEM->WB handshake: MEM offers an instruction, WB answers with allowin.
interface wb_stage_if;
  logic        ms_valid;
  logic [31:0] ms_pc;
  logic        ms_rf_we;
  logic [4:0]  ms_rf_waddr;
  logic [31:0] ms_result;
  logic [2:0]  ms_ld_op;
  logic        ws_allowin;

  modport master (
    output ms_valid, ms_pc, ms_rf_we, ms_rf_waddr, ms_result, ms_ld_op,
    input  ws_allowin
  );

  modport slave (
    input  ms_valid, ms_pc, ms_rf_we, ms_rf_waddr, ms_result, ms_ld_op,
    output ws_allowin
  );
endinterface

// File: rtl/wb_stage_load_align.sv
// Little-endian byte/halfword selection and extension for loads; any
// non-load op passes the word through unchanged.
module load_align
  import wb_stage_pkg::*;
(
  input  logic [2:0]  ld_op,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (offset)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = offset[1] ? word[31:16] : word[15:0];

    case (ld_op)
      3'(LD_B):  data = {{24{byte_sel[7]}}, byte_sel};
      3'(LD_BU): data = {24'd0, byte_sel};
      3'(LD_H):  data = {{16{half_sel[15]}}, half_sel};
      3'(LD_HU): data = {16'd0, half_sel};
      default:   data = word;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: holds one retiring instruction, finishes load data
// alignment and drives the register-file write port and retirement trace.
module wb_stage
  import wb_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  wb_stage_if.slave   ms,
  input  logic [31:0] data_sram_rdata,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_wen,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata
);

  logic                       ws_valid;
  logic                       ws_first;
  ms_to_ws_bus_t              ws_bus;
  logic [31:0]                ld_hold;
  logic                       allowin;
  logic [MS_TO_WS_BUS_WD-1:0] ms_bus_flat;
  logic [31:0]                ld_word;
  logic [31:0]                align_in;

  assign allowin       = rst || !ws_valid || !stall;
  assign ms.ws_allowin = allowin;
  assign ms_bus_flat   = {ms.ms_pc, ms.ms_rf_we, ms.ms_rf_waddr,
                          ms.ms_result, ms.ms_ld_op};

  // SRAM data is only valid in the first WB cycle, so it is parked in
  // ld_hold for any later (stalled) cycles of the same instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      ws_valid <= 1'b0;
      ws_first <= 1'b0;
      ws_bus   <= '0;
      ld_hold  <= '0;
    end else begin
      if (ws_first) ld_hold <= data_sram_rdata;
      if (flush) begin
        ws_valid <= 1'b0;
        ws_first <= 1'b0;
      end else if (allowin) begin
        ws_valid <= ms.ms_valid;
        ws_first <= ms.ms_valid;
        if (ms.ms_valid) ws_bus <= ms_to_ws_bus_t'(ms_bus_flat);
      end else begin
        ws_first <= 1'b0;
      end
    end
  end

  assign ld_word  = ws_first ? data_sram_rdata : ld_hold;
  assign align_in = is_load(ws_bus.ld_op) ? ld_word : ws_bus.result;

  load_align u_load_align (
    .ld_op  (ws_bus.ld_op),
    .offset (ws_bus.result[1:0]),
    .word   (align_in),
    .data   (rf_wdata)
  );

  assign rf_we             = ws_valid && ws_bus.rf_we && !stall && !flush && !rst;
  assign rf_waddr          = ws_bus.rf_waddr;
  assign debug_wb_pc       = ws_bus.pc;
  assign debug_wb_rf_wen   = {4{rf_we && (rf_waddr != 5'd0)}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios followed by random
// traffic, all compared against an occupant-level reference model.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic [31:0] data_sram_rdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;

  int n_checks = 0;
  int n_fails  = 0;
  int n_writes = 0;
  int w0;

  // Reference model: the single instruction sitting in WB.
  logic        m_valid, m_first, m_we;
  logic [31:0] m_pc, m_result, m_hold;
  logic [4:0]  m_waddr;
  logic [2:0]  m_op;

  wb_stage_if ms_if ();

  wb_stage dut (
    .clk               (clk),
    .rst               (rst),
    .stall             (stall),
    .flush             (flush),
    .ms                (ms_if.slave),
    .data_sram_rdata   (data_sram_rdata),
    .rf_we             (rf_we),
    .rf_waddr          (rf_waddr),
    .rf_wdata          (rf_wdata),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_wen   (debug_wb_rf_wen),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] refExtract(input logic [2:0] op,
                                             input logic [31:0] res,
                                             input logic [31:0] word);
    logic [31:0] v;
    int          sh;
    case (op)
      3'd1, 3'd2: begin
        sh = int'(res[1:0]) * 8;
        v  = (word >> sh) & 32'hFF;
        if (op == 3'd1 && v >= 32'h80) v = v - 32'h100;
      end
      3'd3, 3'd4: begin
        sh = res[1] ? 16 : 0;
        v  = (word >> sh) & 32'hFFFF;
        if (op == 3'd3 && v >= 32'h8000) v = v - 32'h10000;
      end
      3'd5:    v = word;
      default: v = res;
    endcase
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fails++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
      $error("[TB] check %s did not hold", tag);
    end
  endtask

  task automatic checkModel();
    logic        e_allow, e_we;
    logic [31:0] e_data;
    e_allow = rst || !m_valid || !stall;
    e_we    = !rst && m_valid && m_we && !stall && !flush;
    e_data  = refExtract(m_op, m_result, m_first ? data_sram_rdata : m_hold);
    checkOutput("allowin", {31'd0, ms_if.ws_allowin}, {31'd0, e_allow});
    checkOutput("rf_we", {31'd0, rf_we}, {31'd0, e_we});
    checkOutput("rf_waddr", {27'd0, rf_waddr}, {27'd0, m_waddr});
    checkOutput("rf_wdata", rf_wdata, e_data);
    checkOutput("dbg_pc", debug_wb_pc, m_pc);
    checkOutput("dbg_wen", {28'd0, debug_wb_rf_wen},
                (e_we && m_waddr != 5'd0) ? 32'hF : 32'h0);
    checkOutput("dbg_wnum", {27'd0, debug_wb_rf_wnum}, {27'd0, m_waddr});
    checkOutput("dbg_wdata", debug_wb_rf_wdata, e_data);
    if (rf_we) n_writes++;
  endtask

  task automatic applyStimulus(input logic r, input logic st, input logic fl,
                               input logic mv, input logic [31:0] pc,
                               input logic we, input logic [4:0] wa,
                               input logic [31:0] res, input logic [2:0] op,
                               input logic [31:0] rd);
    rst               = r;
    stall             = st;
    flush             = fl;
    ms_if.ms_valid    = mv;
    ms_if.ms_pc       = pc;
    ms_if.ms_rf_we    = we;
    ms_if.ms_rf_waddr = wa;
    ms_if.ms_result   = res;
    ms_if.ms_ld_op    = op;
    data_sram_rdata   = rd;
    #4;
    checkModel();
  endtask

  // Advance one cycle, updating the model from the inputs seen at the edge.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      {m_valid, m_first, m_we, m_pc, m_result, m_hold, m_waddr, m_op} = '0;
    end else begin
      if (m_first) m_hold = data_sram_rdata;
      if (flush) begin
        m_valid = 1'b0;
        m_first = 1'b0;
      end else if (!m_valid || !stall) begin
        m_valid = ms_if.ms_valid;
        m_first = ms_if.ms_valid;
        if (ms_if.ms_valid) begin
          m_pc     = ms_if.ms_pc;
          m_we     = ms_if.ms_rf_we;
          m_waddr  = ms_if.ms_rf_waddr;
          m_result = ms_if.ms_result;
          m_op     = ms_if.ms_ld_op;
        end
      end else begin
        m_first = 1'b0;
      end
    end
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; data_sram_rdata = '0;
    ms_if.ms_valid = 1'b0; ms_if.ms_pc = '0; ms_if.ms_rf_we = 1'b0;
    ms_if.ms_rf_waddr = '0; ms_if.ms_result = '0; ms_if.ms_ld_op = '0;
    repeat (2) @(posedge clk);
    #1;
    {m_valid, m_first, m_we, m_pc, m_result, m_hold, m_waddr, m_op} = '0;

    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("reset_allowin", {31'd0, ms_if.ws_allowin}, 32'd1);
    tick();

    // ADDU to $8
    applyStimulus(0, 0, 0, 1, 32'hBFC0_0000, 1, 8, 32'h0000_1234, 0, $urandom);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, $urandom);
    checkOutput("addu_we", {31'd0, rf_we}, 32'd1);
    checkOutput("addu_waddr", {27'd0, rf_waddr}, 32'd8);
    checkOutput("addu_wdata", rf_wdata, 32'h0000_1234);
    checkOutput("addu_wen", {28'd0, debug_wb_rf_wen}, 32'hF);
    tick();

    // LB then LBU at byte offset 3
    applyStimulus(0, 0, 0, 1, 32'hBFC0_0010, 1, 4, 32'h0000_1003, 1, 0);
    tick();
    applyStimulus(0, 0, 0, 1, 32'hBFC0_0014, 1, 5, 32'h0000_1003, 2, 32'h80FF_0011);
    checkOutput("lb_wdata", rf_wdata, 32'hFFFF_FF80);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h80FF_0011);
    checkOutput("lbu_wdata", rf_wdata, 32'h0000_0080);
    tick();

    // LH at offset 2, stalled for three cycles, SRAM data gone meanwhile
    applyStimulus(0, 0, 0, 1, 32'hBFC0_0020, 1, 9, 32'h0000_2002, 3, 0);
    tick();
    w0 = n_writes;
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h8001_7FFF);
    checkOutput("lh_stall_we", {31'd0, rf_we}, 32'd0);
    tick();
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("lh_we", {31'd0, rf_we}, 32'd1);
    checkOutput("lh_wdata", rf_wdata, 32'hFFFF_8001);
    checkOutput("lh_writes", n_writes - w0, 32'd1);
    tick();

    // Write to $0
    applyStimulus(0, 0, 0, 1, 32'hBFC0_0030, 1, 0, 32'h0000_0055, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("r0_we", {31'd0, rf_we}, 32'd1);
    checkOutput("r0_wen", {28'd0, debug_wb_rf_wen}, 32'h0);
    tick();

    // Flush together with stall on a valid load
    applyStimulus(0, 0, 0, 1, 32'hBFC0_0040, 1, 10, 32'h0000_3000, 5, 0);
    tick();
    applyStimulus(0, 1, 1, 0, 0, 0, 0, 0, 0, $urandom);
    checkOutput("flush_we", {31'd0, rf_we}, 32'd0);
    tick();
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, $urandom);
    checkOutput("flush_allowin", {31'd0, ms_if.ws_allowin}, 32'd1);
    checkOutput("flush_we_after", {31'd0, rf_we}, 32'd0);
    tick();

    // Three back-to-back writes, reset during the third one's stall
    w0 = n_writes;
    applyStimulus(0, 0, 0, 1, 32'hBFC0_0050, 1, 1, 32'h111, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 1, 32'hBFC0_0054, 1, 2, 32'h222, 0, 0);
    checkOutput("b2b_w1", {27'd0, rf_waddr}, 32'd1);
    tick();
    applyStimulus(0, 0, 0, 1, 32'hBFC0_0058, 1, 3, 32'h333, 0, 0);
    checkOutput("b2b_w2", {27'd0, rf_waddr}, 32'd2);
    tick();
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rst_we", {31'd0, rf_we}, 32'd0);
    checkOutput("rst_allowin", {31'd0, ms_if.ws_allowin}, 32'd1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("post_rst_wdata", rf_wdata, 32'd0);
    checkOutput("post_rst_pc", debug_wb_pc, 32'd0);
    checkOutput("post_rst_wnum", {27'd0, debug_wb_rf_wnum}, 32'd0);
    checkOutput("b2b_writes", n_writes - w0, 32'd2);
    tick();

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 49) == 0, $urandom_range(0, 9) < 3,
                    $urandom_range(0, 11) == 0, $urandom_range(0, 9) < 7,
                    $urandom, 1'($urandom), 5'($urandom), $urandom,
                    3'($urandom_range(0, 7)), $urandom);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
